// File: rtl/fetch_controller.sv
// Instruction fetch controller: PC sequencing, branch redirect with one
// bubble, stall hold, and end-of-program halt.
module fetch_controller #(
  parameter int                ADDR_W     = 22,
  parameter int                DATA_W     = 22,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                PROG_WORDS = 101
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rd,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              done,
  output logic              misalign_err,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LIM = ADDR_W'(PROG_WORDS);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] pc_q;
  logic              in_range;
  logic              take_br;
  logic              issue;

  assign in_range = {2'b00, pc_q[ADDR_W-1:2]} < LIM;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FLUSH without stall issues the redirect target directly,
  // so a branch costs exactly one bubble.
  always_comb begin
    state_d = state_q;
    take_br = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH, FLUSH: begin
        if (branch_taken) begin
          take_br = 1'b1;
          state_d = FLUSH;
        end else if (!stall) begin
          if (in_range) begin
            issue   = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      instr        <= '0;
      instr_pc     <= '0;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else if (take_br) begin
      pc_q        <= {branch_target[ADDR_W-1:2], 2'b00};
      instr_valid <= 1'b0;
      if (branch_target[1:0] != 2'b00) misalign_err <= 1'b1;
    end else if (issue) begin
      instr       <= imem_rd;
      instr_pc    <= pc_q;
      instr_valid <= 1'b1;
      pc_q        <= pc_q + ADDR_W'(4);
      if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
    end else if (state_d == DONE) begin
      instr_valid <= 1'b0;
    end
  end

  assign imem_addr = pc_q;
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with an issue scoreboard and a
// second short-program instance for the end-of-program halt.
module tb_fetch_controller;

  localparam int AW = 22;
  localparam int DW = 22;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] ins;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          stall;
  logic          branch_taken;
  logic [AW-1:0] branch_target;

  logic [AW-1:0] imem_addr, s_imem_addr;
  logic [DW-1:0] imem_rd, s_imem_rd;
  logic [DW-1:0] instr, s_instr;
  logic [AW-1:0] instr_pc, s_instr_pc;
  logic          instr_valid, s_instr_valid;
  logic          done, s_done;
  logic          misalign_err, s_misalign_err;
  logic [15:0]   fetch_count, s_fetch_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  logic [15:0] last_cnt = '0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return DW'(a[AW-1:2] * 37 + 22'h1234);
  endfunction

  assign imem_rd   = memf(imem_addr);
  assign s_imem_rd = memf(s_imem_addr);

  fetch_controller u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .done(done),
    .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  fetch_controller #(.PROG_WORDS(4)) u_short (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(s_imem_addr), .imem_rd(s_imem_rd), .instr(s_instr),
    .instr_pc(s_instr_pc), .instr_valid(s_instr_valid), .done(s_done),
    .misalign_err(s_misalign_err), .fetch_count(s_fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] pc);
    exp_t e;
    e.pc  = pc;
    e.ins = memf(pc);
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && instr_valid && fetch_count != last_cnt) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_issue", 32'(instr_pc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_pc", 32'(instr_pc), 32'(e.pc));
        chk("sb_instr", 32'(instr), 32'(e.ins));
      end
    end
    last_cnt = fetch_count;
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    #3;
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(fetch_count), 0);
    chk("rst_mis", 32'(misalign_err), 0);
    step();
    step();
    rst_n = 1'b1;

    start = 1'b1;
    for (int i = 0; i < 9; i++) push(AW'(4 * i));
    step();
    start = 1'b0;
    chk("idle_exit_valid", 32'(instr_valid), 0);
    chk("idle_exit_addr", 32'(imem_addr), 0);
    step();
    chk("first_valid", 32'(instr_valid), 1);
    chk("first_pc", 32'(instr_pc), 0);
    step();
    step();
    chk("pc8", 32'(instr_pc), 8);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", 32'(instr_pc), 8);
      chk("stall_addr", 32'(imem_addr), 12);
      chk("stall_count", 32'(fetch_count), 3);
      chk("stall_valid", 32'(instr_valid), 1);
    end
    stall = 1'b0;
    step();
    chk("resume_pc", 32'(instr_pc), 12);
    chk("short_pc12", 32'(s_instr_pc), 12);
    chk("short_cnt4", 32'(s_fetch_count), 4);
    step();
    chk("short_done", 32'(s_done), 1);
    chk("short_valid0", 32'(s_instr_valid), 0);
    for (int i = 0; i < 4; i++) step();
    chk("seq_count9", 32'(fetch_count), 9);
    chk("seq_pc32", 32'(instr_pc), 32);
    chk("seq_addr36", 32'(imem_addr), 36);

    push(AW'('h14));
    branch_taken = 1'b1;
    stall = 1'b1;
    branch_target = AW'('h14);
    step();
    chk("br_valid0", 32'(instr_valid), 0);
    chk("br_addr", 32'(imem_addr), 'h14);
    chk("br_count", 32'(fetch_count), 9);
    branch_taken = 1'b0;
    stall = 1'b0;
    step();
    chk("br_issue_valid", 32'(instr_valid), 1);
    chk("br_issue_pc", 32'(instr_pc), 'h14);
    chk("br_mis0", 32'(misalign_err), 0);

    push(AW'('h14));
    branch_taken = 1'b1;
    branch_target = AW'('h17);
    step();
    chk("mis_addr", 32'(imem_addr), 'h14);
    chk("mis_flag", 32'(misalign_err), 1);
    chk("mis_valid0", 32'(instr_valid), 0);
    branch_taken = 1'b0;
    step();
    chk("mis_issue_pc", 32'(instr_pc), 'h14);
    stall = 1'b1;
    step();
    step();
    chk("mis_sticky", 32'(misalign_err), 1);
    chk("mis_count", 32'(fetch_count), 11);

    stall = 1'b0;
    branch_taken = 1'b1;
    branch_target = AW'('h194);
    step();
    chk("oor_valid0", 32'(instr_valid), 0);
    chk("oor_done0", 32'(done), 0);
    branch_taken = 1'b0;
    step();
    chk("oor_done", 32'(done), 1);
    chk("oor_valid", 32'(instr_valid), 0);
    start = 1'b1;
    branch_taken = 1'b1;
    branch_target = '0;
    step();
    step();
    chk("done_hold", 32'(done), 1);
    chk("done_addr", 32'(imem_addr), 'h194);
    chk("done_count", 32'(fetch_count), 11);
    chk("done_mis", 32'(misalign_err), 1);
    chk("short_hold_addr", 32'(s_imem_addr), 16);
    chk("short_hold_cnt", 32'(s_fetch_count), 4);
    chk("short_hold_pc", 32'(s_instr_pc), 12);
    start = 1'b0;
    branch_taken = 1'b0;

    rst_n = 1'b0;
    #1;
    chk("rst2_done", 32'(done), 0);
    chk("rst2_mis", 32'(misalign_err), 0);
    chk("rst2_addr", 32'(imem_addr), 0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("idle_wait_valid", 32'(instr_valid), 0);
    chk("idle_wait_addr", 32'(imem_addr), 0);

    push(AW'(0));
    push(AW'(4));
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("pre_async_pc", 32'(instr_pc), 4);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_addr", 32'(imem_addr), 0);
    chk("async_valid", 32'(instr_valid), 0);
    chk("async_instr", 32'(instr), 0);
    chk("async_pc", 32'(instr_pc), 0);
    chk("async_count", 32'(fetch_count), 0);
    step();
    rst_n = 1'b1;
    push(AW'(0));
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("restart_pc", 32'(instr_pc), 0);
    chk("restart_valid", 32'(instr_valid), 1);
    chk("restart_count", 32'(fetch_count), 1);
    stall = 1'b1;
    step();
    chk("sb_drained", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter ADDR_W, default 22, byte-address width of PC and memory address.
REQ-002 Parameter DATA_W, default 22, instruction width.
REQ-003 Parameter RESET_PC, default 0, PC loaded on reset; SHALL be word aligned.
REQ-004 Parameter PROG_WORDS, default 101, number of valid instruction words; fetch beyond this halts.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  pulse or level; leaves IDLE and begins fetching.
REQ-008 stall  input  1  pipeline hold; freezes PC and output registers.
REQ-009 branch_taken  input  1  redirect request, valid in the same cycle as branch_target.
REQ-010 branch_target  input  ADDR_W  byte address of redirect.
REQ-011 imem_addr  output  ADDR_W  byte address to instruction memory; memory reads combinationally, word index = imem_addr[ADDR_W-1:2].
REQ-012 imem_rd  input  DATA_W  instruction word returned for imem_addr in the same cycle.
REQ-013 instr  output  DATA_W  registered fetched instruction.
REQ-014 instr_pc  output  ADDR_W  registered byte address of instr.
REQ-015 instr_valid  output  1  instr/instr_pc hold a real instruction (not a bubble).
REQ-016 done  output  1  controller in DONE state.
REQ-017 misalign_err  output  1  sticky flag, set by a misaligned branch_target.
REQ-018 fetch_count  output  16  number of instructions issued with instr_valid=1; saturates at 16'hFFFF.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, FLUSH, DONE; encoding is free.
REQ-020 imem_addr SHALL equal the PC register combinationally in every state.
REQ-021 IDLE: instr_valid=0, PC held; start=1 -> FETCH on the next edge.
REQ-022 FETCH with stall=0 and branch_taken=0: instr<=imem_rd, instr_pc<=PC, instr_valid<=1, PC<=PC+4, fetch_count increments; latency from PC to instr is exactly 1 cycle.
REQ-023 FETCH with stall=1 and branch_taken=0: PC, instr, instr_pc, instr_valid, fetch_count SHALL all hold.
REQ-024 branch_taken=1 in FETCH or FLUSH SHALL take priority over stall: PC<=branch_target with bits [1:0] forced to 0, instr_valid<=0, next state FLUSH.
REQ-025 misalign_err SHALL set when branch_taken=1 and branch_target[1:0]!=0, and clears only on reset.
REQ-026 FLUSH lasts exactly one cycle (one bubble) then returns to FETCH; stall in FLUSH extends it, holding instr_valid=0.
REQ-027 When a FETCH update would issue PC with PC[ADDR_W-1:2] >= PROG_WORDS, the controller SHALL not issue it; instead instr_valid<=0 and next state DONE.
REQ-028 A branch whose target word index >= PROG_WORDS SHALL go to FLUSH, then DONE without issuing.
REQ-029 DONE: instr_valid=0, PC and outputs hold, branch/stall/start ignored; exit only by reset.
REQ-030 PC+4 SHALL wrap modulo 2^ADDR_W; no carry-out is kept.
REQ-031 start is ignored outside IDLE.

Reset
REQ-032 rst_n=0 SHALL immediately, independent of clk, force: state IDLE, PC=RESET_PC, imem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, done=0, misalign_err=0, fetch_count=0.
REQ-033 Reset asserted mid-fetch or mid-flush SHALL discard the in-flight instruction; after release the block waits in IDLE for start.

Verification
REQ-034 Sequential run: reset, start, memory words 0..8 preloaded -> instr_valid high from cycle 2, instr_pc=0,4,8,...,32 on consecutive cycles, fetch_count=9 after 9 issues.
REQ-035 Stall: assert stall for 3 cycles while instr_pc=8 -> instr_pc stays 8, imem_addr stays 12, fetch_count unchanged, resumes at 12.
REQ-036 Branch with stall: branch_taken=1, stall=1, target=0x14 -> next cycle instr_valid=0, imem_addr=0x14, then instr_pc=0x14 with instr_valid=1.
REQ-037 Misaligned branch: target=0x17 -> imem_addr=0x14, misalign_err=1 persists until reset.
REQ-038 End of program: PROG_WORDS=4 -> issues instr_pc 0,4,8,12, then done=1, instr_valid=0, further start/branch ignored.
REQ-039 Async reset: drop rst_n between clock edges while in FETCH -> outputs reach reset values before the next edge; after release plus start, fetch restarts at RESET_PC.
